wbu_txuart: RTL and testbench



---
 rtl/wbu_txuart.sv | 165 ++++++++++++++++
 tb/tb_wbu_txuart.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_txuart.sv
// wbu_txuart: 8N1 serial transmitter fed by the debug-bus/console arbiter.
// Each accepted byte is framed as start(0), eight data bits LSB first and
// stop(1), every bit lasting CLOCKS_PER_BAUD clocks.  o_busy drops during the
// last clock of the stop bit so a waiting byte starts with no idle gap.
// Optional build macro WBU_TXUART_CTS_EN adds i_cts_n hardware flow control.
module wbu_txuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_stb,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_uart_tx
`ifdef WBU_TXUART_CTS_EN
  ,
  input  logic       i_cts_n
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        busy_q, busy_d;
  logic        tx_q, tx_d;

  logic        accept;
  logic        cnt_last;
  logic        cts_hold;

`ifdef WBU_TXUART_CTS_EN
  logic [1:0] cts_sync_q, cts_sync_d;

  // Two-flop synchroniser for the asynchronous clear-to-send input.
  always_comb begin
    cts_sync_d = {cts_sync_q[0], i_cts_n};
  end

  // Synchroniser flops; reset to "not clear" so nothing leaves before CTS is seen.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cts_sync_q <= 2'b11;
    end else begin
      cts_sync_q <= cts_sync_d;
    end
  end

  assign cts_hold = cts_sync_q[1];
`else
  assign cts_hold = 1'b0;
`endif

  // o_busy low already encodes "free and clear to send", so it alone gates accept.
  assign accept   = i_stb && !busy_q;
  assign cnt_last = (cnt_q == 24'd0);

  // Next-state logic: bit timing, shifting, and the accept/back-to-back path.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    tx_d    = tx_q;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = cts_hold;
        if (accept) begin
          shift_d = i_data;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = BAUD_RELOAD;
          state_d = START;
        end
      end

      START: begin
        if (cnt_last) begin
          cnt_d   = BAUD_RELOAD;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end

      DATA: begin
        if (cnt_last) begin
          cnt_d = BAUD_RELOAD;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end

      STOP: begin
        if (cnt_last) begin
          if (accept) begin
            shift_d = i_data;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
            cnt_d   = BAUD_RELOAD;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            busy_d  = cts_hold;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
          // Release busy one clock early so the arbiter can queue the next byte.
          if (cnt_q == 24'd1) begin
            busy_d = cts_hold;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; the shift register holds data only and is not reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 24'd0;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
    shift_q <= shift_d;
  end

  assign o_busy    = busy_q;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_wbu_txuart.sv
// Bench for wbu_txuart with CLOCKS_PER_BAUD = 4.  A frame-level model turns
// every accepted byte into its expected 40-cycle (tx, busy) waveform; a
// negedge process compares the DUT against it, and directed tasks add
// hand-written frame patterns.
module tb_wbu_txuart;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stb;
  logic [7:0] data;
  logic       busy;
  logic       tx;
`ifdef WBU_TXUART_CTS_EN
  logic       cts_n;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en  = 1'b1;
  bit started = 1'b0;

  wbu_txuart #(.CLOCKS_PER_BAUD(24'd4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_stb     (stb),
    .i_data    (data),
    .o_busy    (busy),
    .o_uart_tx (tx)
`ifdef WBU_TXUART_CTS_EN
    ,
    .i_cts_n   (cts_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct packed {logic tx; logic busy;} smp_t;
  smp_t q[$];
  smp_t cur = '{tx: 1'b1, busy: 1'b0};

  task automatic push_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++)
      q.push_back('{tx: bits[i / CPB], busy: (i != 10 * CPB - 1)});
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      cur = '{tx: 1'b1, busy: 1'b0};
      started = 1'b1;
    end else begin
      if (stb && !cur.busy) push_frame(data);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{tx: 1'b1, busy: 1'b0};
    end
  end

  always @(negedge clk) begin
    if (chk_en && started) begin
      check("model_tx", tx, cur.tx);
      check("model_busy", busy, cur.busy);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic release_reset();
`ifdef WBU_TXUART_CTS_EN
    chk_en = 1'b0;
`endif
    rst_n = 1'b1;
    idle(4);
    chk_en = 1'b1;
  endtask

  // Call right after the accept edge; walks the 40 cycles of the frame.
  task automatic run_frame(input string name, input logic [9:0] word, input int chg_k,
                           input logic nstb, input logic [7:0] ndata);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      check({name, "_tx"}, tx, word[k / CPB]);
      if (k == 0 || k == 10 * CPB - 1) check({name, "_busy"}, busy, (k != 10 * CPB - 1));
      if (k == chg_k) begin
        stb  = nstb;
        data = ndata;
      end
    end
  endtask

  task automatic start_byte(input logic [7:0] b);
    @(negedge clk);
    stb  = 1'b1;
    data = b;
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    stb   = 1'b0;
    data  = 8'h00;
`ifdef WBU_TXUART_CTS_EN
    cts_n = 1'b0;
`endif
    // Reset with a strobe pending: must be ignored.
    @(negedge clk);
    stb  = 1'b1;
    data = 8'h99;
    idle(2);
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    stb = 1'b0;
    release_reset();

    // 100 idle cycles: the compare process checks every one.
    idle(100);
    check("idle_tx", tx, 1'b1);
    check("idle_busy", busy, 1'b0);

    // Single byte 0xA5: levels 0,1,0,1,0,0,1,0,1,1.
    start_byte(8'hA5);
    run_frame("a5", 10'b1101001010, 0, 1'b0, 8'h00);
    idle(5);

    // Back-to-back 0x41 then 0x0D, strobe held throughout.
    start_byte(8'h41);
    run_frame("b2b_41", 10'b1010000010, 0, 1'b1, 8'h0D);
    run_frame("b2b_0d", 10'b1000011010, 0, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("b2b_after_tx", tx, 1'b1);
    end

    // Data changes while busy: frame keeps the latched 0x3C.
    start_byte(8'h3C);
    run_frame("latch", 10'b1001111000, 5, 1'b0, 8'hFF);
    idle(5);

    // Mid-frame reset in cycle 13 of a 0xFF frame.
    start_byte(8'hFF);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      if (k == 0) stb = 1'b0;
      if (k == 13) begin
        check("ff_bit3_tx", tx, 1'b1);
        rst_n = 1'b0;
      end
    end
    @(negedge clk);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    release_reset();
    start_byte(8'h00);
    run_frame("after_rst_00", 10'b1000000000, 0, 1'b0, 8'h00);
    idle(5);

`ifdef WBU_TXUART_CTS_EN
    begin
      bit found;
      chk_en = 1'b0;
      cts_n  = 1'b1;
      idle(4);
      stb  = 1'b1;
      data = 8'h55;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("cts_block_busy", busy, 1'b1);
        check("cts_block_tx", tx, 1'b1);
      end
      cts_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
        @(negedge clk);
        if (tx == 1'b0) found = 1'b1;
      end
      check("cts_start_seen", found, 1'b1);
      stb = 1'b0;
      for (int k = 1; k < 10 * CPB; k++) begin
        @(negedge clk);
        if (k == 10) begin
          cts_n = 1'b1;
          stb   = 1'b1;
          data  = 8'h77;
        end
        if ((k % CPB) == 2) check("cts_frame_tx", tx, logic'((10'b1010101010 >> (k / CPB)) & 10'd1));
      end
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check("cts_wait_tx", tx, 1'b1);
        check("cts_wait_busy", busy, 1'b1);
      end
      cts_n = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge clk);
        if (tx == 1'b0) found = 1'b1;
      end
      check("cts_resume_seen", found, 1'b1);
      stb = 1'b0;
      idle(45);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
